// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, fetches from a 32-word memory into a 1-entry buffer toward decode
module fetch_controller #(
  parameter int          MEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] readAddress,
  input  logic [31:0] instruction,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [1:0]  state_o,
  output logic [15:0] fetch_count
);
  localparam logic [31:0] PC_LIMIT = 32'(MEM_DEPTH * 4);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_FETCH = 2'b01, S_HALT = 2'b10} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst_out, w_inst_out_nxt;
  logic [31:0] r_inst_pc, w_inst_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_fault, w_fault_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic        w_legal, w_slot_free;
  logic [31:0] w_pc_inc;
  logic [15:0] w_count_inc;

  assign w_legal     = (redirect_pc[1:0] == 2'b00) && (redirect_pc < PC_LIMIT);
  assign w_slot_free = !r_valid || inst_ready;
  assign w_pc_inc    = (r_pc >= PC_LIMIT - 32'd4) ? 32'd0 : r_pc + 32'd4;
  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

  assign readAddress = r_pc;
  assign inst_out    = r_inst_out;
  assign inst_pc     = r_inst_pc;
  assign inst_valid  = r_valid;
  assign fault       = r_fault;
  assign state_o     = r_state;
  assign fetch_count = r_count;

  // Next-state and datapath decisions; a buffered word drains once decode accepts it
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inst_out_nxt = r_inst_out;
    w_inst_pc_nxt  = r_inst_pc;
    w_valid_nxt    = r_valid && !inst_ready;
    w_fault_nxt    = r_fault;
    w_count_nxt    = r_count;
    case (r_state)
      S_IDLE: begin
        w_pc_nxt    = (redirect && w_legal) ? redirect_pc : r_pc;
        w_state_nxt = start ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        if (redirect) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_legal ? redirect_pc : r_pc;
          w_fault_nxt = r_fault || !w_legal;
          w_state_nxt = w_legal ? S_FETCH : S_HALT;
        end else if (w_slot_free) begin
          w_inst_out_nxt = instruction;
          w_inst_pc_nxt  = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = w_pc_inc;
          w_count_nxt    = w_count_inc;
          w_state_nxt    = (instruction == HALT_WORD) ? S_HALT : S_FETCH;
        end else begin
          w_valid_nxt = r_valid;
        end
      end
      S_HALT: begin
        if (start) begin
          w_pc_nxt    = RESET_PC;
          w_fault_nxt = 1'b0;
          w_count_nxt = 16'd0;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // PC, output buffer, fault flag and capture counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inst_out <= 32'd0;
      r_inst_pc  <= 32'd0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_count    <= 16'd0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_inst_out <= w_inst_out_nxt;
      r_inst_pc  <= w_inst_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_fault    <= w_fault_nxt;
      r_count    <= w_count_nxt;
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus randomized run against a behavioural fetch model
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        rst_n, start, redirect, inst_ready;
  logic [31:0] redirect_pc, instruction, readAddress, inst_out, inst_pc;
  logic        inst_valid, fault;
  logic [1:0]  state_o;
  logic [15:0] fetch_count;
  logic [31:0] mem [32];
  int          n_pass = 0, n_total = 0;

  logic [31:0] m_pc, m_out, m_ipc;
  logic        m_valid, m_fault;
  int          m_state, m_count;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .readAddress(readAddress),
    .instruction(instruction), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .fault(fault), .state_o(state_o), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign instruction = mem[readAddress[6:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'(i + 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; inst_ready = 1'b0; redirect_pc = 32'd0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start = 1'($urandom); redirect = 1'($urandom); inst_ready = 1'($urandom); redirect_pc = $urandom;
      tick();
      n_total++;
      if ({readAddress, inst_out, inst_pc, inst_valid, fault, state_o, fetch_count} !== '0)
        $display("FAIL reset_hold got pc=%h out=%h ipc=%h v=%b f=%b st=%b cnt=%h exp all zero",
                 readAddress, inst_out, inst_pc, inst_valid, fault, state_o, fetch_count);
      else n_pass++;
    end
    do_reset();
    inst_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({readAddress, inst_out, inst_pc, inst_valid, fault, state_o, fetch_count} !== '0)
      $display("FAIL reset_async got pc=%h out=%h ipc=%h v=%b st=%b cnt=%h exp all zero",
               readAddress, inst_out, inst_pc, inst_valid, state_o, fetch_count);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    inst_ready = 1'b1;
    pulse_start();
    n_total++;
    if ({inst_valid, state_o} !== 3'b0_01) $display("FAIL stream_first got v=%b st=%b exp v=0 st=01", inst_valid, state_o);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++;
      if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'(4 * k), 32'(k + 1)})
        $display("FAIL stream_%0d got v=%b pc=%h out=%h exp v=1 pc=%h out=%h", k, inst_valid, inst_pc, inst_out, 4 * k, k + 1);
      else n_pass++;
    end
    n_total++;
    if (fetch_count !== 16'd4) $display("FAIL stream_count got %0d exp 4", fetch_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b1;
    pulse_start();
    tick(); tick(); tick();
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if ({inst_valid, inst_pc, inst_out, readAddress} !== {1'b1, 32'd8, 32'd3, 32'd12})
        $display("FAIL bp_hold_%0d got v=%b ipc=%h out=%h ra=%h exp v=1 ipc=8 out=3 ra=c", k, inst_valid, inst_pc, inst_out, readAddress);
      else n_pass++;
    end
    inst_ready = 1'b1;
    tick();
    n_total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'd12, 32'd4})
      $display("FAIL bp_release got v=%b ipc=%h out=%h exp v=1 ipc=c out=4", inst_valid, inst_pc, inst_out);
    else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    inst_ready = 1'b1;
    pulse_start();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    n_total++;
    if ({inst_valid, readAddress} !== {1'b0, 32'h40})
      $display("FAIL redir_flush got v=%b ra=%h exp v=0 ra=40", inst_valid, readAddress);
    else n_pass++;
    tick();
    n_total++;
    if ({inst_valid, inst_pc, inst_out, fetch_count} !== {1'b1, 32'h40, 32'd17, 16'd4})
      $display("FAIL redir_target got v=%b ipc=%h out=%h cnt=%0d exp v=1 ipc=40 out=11 cnt=4", inst_valid, inst_pc, inst_out, fetch_count);
    else n_pass++;
  endtask

  task automatic test_fault();
    do_reset();
    inst_ready = 1'b1;
    pulse_start();
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    n_total++;
    if ({fault, state_o, inst_valid, readAddress} !== {1'b1, 2'b10, 1'b0, 32'd8})
      $display("FAIL fault_misalign got f=%b st=%b v=%b ra=%h exp f=1 st=10 v=0 ra=8", fault, state_o, inst_valid, readAddress);
    else n_pass++;
    redirect_pc = 32'h10;
    tick();
    redirect = 1'b0;
    n_total++;
    if ({fault, state_o, inst_valid, readAddress} !== {1'b1, 2'b10, 1'b0, 32'd8})
      $display("FAIL halt_ignore_redir got f=%b st=%b v=%b ra=%h exp f=1 st=10 v=0 ra=8", fault, state_o, inst_valid, readAddress);
    else n_pass++;
    pulse_start();
    n_total++;
    if ({fault, state_o, inst_valid, readAddress, fetch_count} !== {1'b0, 2'b01, 1'b0, 32'd0, 16'd0})
      $display("FAIL fault_restart got f=%b st=%b v=%b ra=%h cnt=%0d exp f=0 st=01 v=0 ra=0 cnt=0", fault, state_o, inst_valid, readAddress, fetch_count);
    else n_pass++;
    tick();
    n_total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'd0, 32'd1})
      $display("FAIL fault_refetch got v=%b ipc=%h out=%h exp v=1 ipc=0 out=1", inst_valid, inst_pc, inst_out);
    else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    n_total++;
    if ({fault, state_o, inst_valid, readAddress} !== {1'b1, 2'b10, 1'b0, 32'd4})
      $display("FAIL fault_range got f=%b st=%b v=%b ra=%h exp f=1 st=10 v=0 ra=4", fault, state_o, inst_valid, readAddress);
    else n_pass++;
  endtask

  task automatic test_wrap_halt();
    mem[31] = 32'd1234;
    mem[0]  = 32'hFFFF_FFFF;
    do_reset();
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h7C;
    tick();
    redirect = 1'b0;
    n_total++;
    if ({state_o, inst_valid, readAddress} !== {2'b00, 1'b0, 32'h7C})
      $display("FAIL idle_redirect got st=%b v=%b ra=%h exp st=00 v=0 ra=7c", state_o, inst_valid, readAddress);
    else n_pass++;
    pulse_start();
    tick();
    n_total++;
    if ({inst_valid, inst_pc, inst_out, readAddress} !== {1'b1, 32'h7C, 32'd1234, 32'd0})
      $display("FAIL wrap_last got v=%b ipc=%h out=%h ra=%h exp v=1 ipc=7c out=4d2 ra=0", inst_valid, inst_pc, inst_out, readAddress);
    else n_pass++;
    tick();
    n_total++;
    if ({inst_valid, inst_pc, inst_out, state_o, readAddress} !== {1'b1, 32'h0, 32'hFFFF_FFFF, 2'b10, 32'd4})
      $display("FAIL halt_capture got v=%b ipc=%h out=%h st=%b ra=%h exp v=1 ipc=0 out=ffffffff st=10 ra=4", inst_valid, inst_pc, inst_out, state_o, readAddress);
    else n_pass++;
    tick(); tick(); tick();
    n_total++;
    if ({inst_valid, state_o, fetch_count, readAddress} !== {1'b0, 2'b10, 16'd2, 32'd4})
      $display("FAIL halt_stop got v=%b st=%b cnt=%0d ra=%h exp v=0 st=10 cnt=2 ra=4", inst_valid, state_o, fetch_count, readAddress);
    else n_pass++;
    fill_mem();
  endtask

  task automatic model_step();
    logic [31:0] w;
    bit legal;
    w = mem[m_pc[6:2]];
    legal = (redirect_pc % 4 == 0) && (redirect_pc < 128);
    if (m_state == 0) begin
      if (redirect && legal) m_pc = redirect_pc;
      m_valid = m_valid && !inst_ready;
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      if (redirect) begin
        m_valid = 1'b0;
        if (legal) m_pc = redirect_pc;
        else begin m_fault = 1'b1; m_state = 2; end
      end else if (!m_valid || inst_ready) begin
        m_out = w; m_ipc = m_pc; m_valid = 1'b1;
        m_pc = (m_pc + 4) % 128;
        if (m_count < 65535) m_count++;
        if (w == 32'hFFFF_FFFF) m_state = 2;
      end
    end else begin
      if (start) begin m_pc = 0; m_fault = 1'b0; m_count = 0; m_valid = 1'b0; m_state = 1; end
      else m_valid = m_valid && !inst_ready;
    end
  endtask

  task automatic test_random();
    logic [115:0] got, exp;
    int r;
    for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
    do_reset();
    m_pc = 0; m_out = 0; m_ipc = 0; m_valid = 0; m_fault = 0; m_state = 0; m_count = 0;
    for (int c = 0; c < 1500; c++) begin
      inst_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 9) == 0;
      start = $urandom_range(0, 19) == 0;
      r = $urandom_range(0, 7);
      redirect_pc = (r == 0) ? $urandom : 32'($urandom_range(0, 31)) * 4 + ((r == 1) ? 32'd2 : 32'd0);
      model_step();
      tick();
      got = {readAddress, inst_out, inst_pc, inst_valid, fault, state_o, fetch_count};
      exp = {m_pc, m_out, m_ipc, m_valid, m_fault, 2'(m_state), 16'(m_count)};
      n_total++;
      if (got !== exp) $display("FAIL rand cyc=%0d got=%h exp=%h", c, got, exp);
      else n_pass++;
    end
    start = 1'b0; redirect = 1'b0;
    fill_mem();
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_wrap_halt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
